// File: rtl/stopwatch_lap_buffer_if.sv
// Lap-buffer bus: stopwatch time and button levels in, head lap record and status out.
interface stopwatch_lap_buffer_if #(
  parameter int PTR_W = 3
);
  logic [9:0]     ms_in;
  logic [5:0]     sec_in;
  logic [5:0]     min_in;
  logic           lap;
  logic           next;
  logic           clear;
  logic [9:0]     lap_ms;
  logic [5:0]     lap_sec;
  logic [5:0]     lap_min;
  logic           lap_valid;
  logic [PTR_W:0] lap_count;
  logic           full;
  logic           overflow;

  modport master (
    output ms_in, sec_in, min_in, lap, next, clear,
    input  lap_ms, lap_sec, lap_min, lap_valid, lap_count, full, overflow
  );

  modport slave (
    input  ms_in, sec_in, min_in, lap, next, clear,
    output lap_ms, lap_sec, lap_min, lap_valid, lap_count, full, overflow
  );
endinterface

// File: rtl/stopwatch_lap_buffer.sv
// Lap-record FIFO fed by the 1 kHz stopwatch counter; outputs show the head record.
// Optional LAP_SPLIT_DELTA_EN: store split times (delta to previous accepted lap).
module stopwatch_lap_buffer #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input logic                 clk1KHz,
  input logic                 reset,
  stopwatch_lap_buffer_if.slave bus
);
  localparam int             REC_W   = 22;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ONE_C   = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] ONE_P = PTR_W'(1);

  logic [REC_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx;
  logic [PTR_W:0]   count, count_nx;
  logic             lap_q, next_q;
  logic             overflow_r, overflow_nx;
  logic             press_lap, press_next, pop, push;
  logic [REC_W-1:0] rec_new, head_nx;

`ifdef LAP_SPLIT_DELTA_EN
  logic [9:0] base_ms;
  logic [5:0] base_sec, base_min;

  // Positional time subtraction with ms->sec->min borrows; minutes wrap modulo 60.
  function automatic logic [REC_W-1:0] split_delta(
    input logic [9:0] ms,   input logic [5:0] sec,   input logic [5:0] mn,
    input logic [9:0] b_ms, input logic [5:0] b_sec, input logic [5:0] b_min
  );
    logic signed [11:0] d_ms;
    logic signed [7:0]  d_sec;
    logic signed [7:0]  d_min;
    d_ms  = $signed({2'b00, ms})  - $signed({2'b00, b_ms});
    d_sec = $signed({2'b00, sec}) - $signed({2'b00, b_sec});
    d_min = $signed({2'b00, mn})  - $signed({2'b00, b_min});
    if (d_ms < 0) begin
      d_ms  = d_ms + 12'sd1000;
      d_sec = d_sec - 8'sd1;
    end
    if (d_sec < 0) begin
      d_sec = d_sec + 8'sd60;
      d_min = d_min - 8'sd1;
    end
    if (d_min < 0) d_min = d_min + 8'sd60;
    return {d_ms[9:0], d_sec[5:0], d_min[5:0]};
  endfunction

  assign rec_new = split_delta(bus.ms_in, bus.sec_in, bus.min_in, base_ms, base_sec, base_min);

  always_ff @(posedge clk1KHz or posedge reset) begin
    if (reset) begin
      base_ms  <= '0;
      base_sec <= '0;
      base_min <= '0;
    end else if (bus.clear) begin
      base_ms  <= '0;
      base_sec <= '0;
      base_min <= '0;
    end else if (push) begin
      base_ms  <= bus.ms_in;
      base_sec <= bus.sec_in;
      base_min <= bus.min_in;
    end
  end
`else
  assign rec_new = {bus.ms_in, bus.sec_in, bus.min_in};
`endif

  // Next-state: clear beats pop beats push; a pop frees room for a push into a full buffer.
  always_comb begin
    press_lap   = bus.lap & ~lap_q;
    press_next  = bus.next & ~next_q;
    pop         = ~bus.clear & press_next & (count != '0);
    push        = ~bus.clear & press_lap & ((count != DEPTH_C) | pop);
    rd_ptr_nx   = rd_ptr;
    wr_ptr_nx   = wr_ptr;
    count_nx    = count;
    overflow_nx = overflow_r;
    if (bus.clear) begin
      rd_ptr_nx   = '0;
      wr_ptr_nx   = '0;
      count_nx    = '0;
      overflow_nx = 1'b0;
    end else begin
      if (pop)  rd_ptr_nx = rd_ptr + ONE_P;
      if (push) wr_ptr_nx = wr_ptr + ONE_P;
      if (push & ~pop)      count_nx = count + ONE_C;
      else if (pop & ~push) count_nx = count - ONE_C;
      if (press_lap & ~push) overflow_nx = 1'b1;
    end
    // The record being written this edge is not in mem yet, so bypass it when it becomes head.
    head_nx = '0;
    if (count_nx != '0)
      head_nx = (push && (rd_ptr_nx == wr_ptr)) ? rec_new : mem[rd_ptr_nx];
  end

  // Registered state and outputs
  always_ff @(posedge clk1KHz or posedge reset) begin
    if (reset) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      overflow_r    <= 1'b0;
      lap_q         <= 1'b0;
      next_q        <= 1'b0;
      bus.lap_ms    <= '0;
      bus.lap_sec   <= '0;
      bus.lap_min   <= '0;
      bus.lap_valid <= 1'b0;
      bus.full      <= 1'b0;
    end else begin
      rd_ptr        <= rd_ptr_nx;
      wr_ptr        <= wr_ptr_nx;
      count         <= count_nx;
      overflow_r    <= overflow_nx;
      lap_q         <= bus.lap;
      next_q        <= bus.next;
      bus.lap_ms    <= head_nx[21:12];
      bus.lap_sec   <= head_nx[11:6];
      bus.lap_min   <= head_nx[5:0];
      bus.lap_valid <= (count_nx != '0);
      bus.full      <= (count_nx == DEPTH_C);
    end
  end

  always_ff @(posedge clk1KHz) begin
    if (push) mem[wr_ptr] <= rec_new;
  end

  assign bus.lap_count = count;
  assign bus.overflow  = overflow_r;
endmodule

// File: doc/stopwatch_lap_buffer.md
Name: stopwatch_lap_buffer

Overview:
- Downstream consumer of the stopwatch counter. Captures its ms/sec/min outputs on each lap-button press into a small FIFO of lap records; the display side reads them back one at a time.
- Runs in the 1 kHz stopwatch tick domain, so captured values are coherent with the counter.
- Lap and next inputs are pre-debounced button levels; this block does its own rising-edge detection.

Parameters:
- DEPTH, 8, number of lap records held; power of 2, 2..64.
- PTR_W, 3, pointer width, must equal log2(DEPTH).

Ports:
- clk1KHz  in  1  1 kHz stopwatch tick clock.
- reset  in  1  asynchronous, active-high.
- ms_in  in  10  stopwatch milliseconds, 0..999.
- sec_in  in  6  stopwatch seconds, 0..59.
- min_in  in  6  stopwatch minutes, 0..59.
- lap  in  1  lap button level; a rising edge captures one record.
- next  in  1  read button level; a rising edge pops the head record.
- clear  in  1  synchronous level; empties the buffer.
- lap_ms  out  10  head record, ms field.
- lap_sec  out  6  head record, sec field.
- lap_min  out  6  head record, min field.
- lap_valid  out  1  head record is valid (buffer not empty).
- lap_count  out  PTR_W+1  records held, 0..DEPTH.
- full  out  1  lap_count == DEPTH.
- overflow  out  1  sticky; a capture was dropped because the buffer was full.

Behaviour:
- Reset (async, active-high) sets all of the following to 0: pointers, lap_count, lap_ms/sec/min, lap_valid, full, overflow, the edge-detect registers lap_q/next_q, and the delta base registers.
- Edge detect: press_lap = lap & ~lap_q; press_next = next & ~next_q. lap_q and next_q are registered every clk1KHz edge. A level held high produces exactly one press.
- Priority at each edge:
  1. clear: pointers and count go to 0, overflow goes to 0, delta base goes to 0. Presses in that cycle are ignored, but lap_q/next_q still update.
  2. press_next with count > 0: rd_ptr increments modulo DEPTH. A pop when empty is ignored, even if a push happens in the same cycle.
  3. press_lap: if count < DEPTH, or a pop is also occurring in this cycle, write {ms_in, sec_in, min_in} (or the delta, see Optional Feature) at wr_ptr, and wr_ptr increments. Otherwise drop the capture and set overflow to 1.
- Count update: +1 for push only, -1 for pop only, unchanged for push and pop together.
- Full buffer with simultaneous push and pop: count stays DEPTH, no overflow, oldest record discarded.
- Outputs are registered, computed from next state, so they reflect the new head at the same edge the press is sampled. Zero latency from press edge to visible change.
- Push into an empty buffer: lap_* take the captured value directly at that edge.
- When the buffer becomes empty, lap_ms/sec/min are forced to 0 and lap_valid is 0.
- full = (count == DEPTH); lap_valid = (count != 0). Both are registered with count.
- Pointers wrap modulo DEPTH with no extra gap; lap_count saturates logically at DEPTH.
- Reset asserted mid-operation discards all records immediately.

Optional Feature:
- Macro: LAP_SPLIT_DELTA_EN.
- Defined: each record stores the split, i.e. the current inputs minus the base register (the previous accepted capture). Subtraction rules:
  - ms: if ms_in < base_ms, add 1000 and borrow 1 from sec.
  - sec: if the borrow pushes it below 0, add 60 and borrow 1 from min.
  - min: modulo 60.
  - The base updates to the raw inputs only on accepted pushes. Dropped captures do not move the base.
  - The base resets and clears to 0, so the first split equals the absolute time.
- Undefined: records store the absolute inputs; no base registers are synthesized.

Test Plan:
- Reset, then three lap presses at inputs 0:01.250, 0:03.100, 1:00.005 -> lap_count=3, head=0:01.250, lap_valid=1, full=0.
- Nine presses with DEPTH=8 -> lap_count=8, full=1, overflow=1. Next press pops -> head is the 2nd record, count=7, overflow stays 1. Then clear -> count=0, overflow=0, lap_* = 0.
- Empty buffer, lap and next rising in the same edge -> count=1, head = captured value. Full buffer, same stimulus -> count=8, no overflow, head advances.
- Lap held high for 50 clk1KHz cycles -> exactly one record.
- LAP_SPLIT_DELTA_EN: captures at 0:01.900 then 0:03.100 -> records 0:01.900 and 0:01.200 (borrow path). Capture at 0:59.950 then 1:00.020 -> second record 0:00.070.
- Reset asserted asynchronously between clock edges with count=5 -> all outputs 0 immediately, before the next edge.
